// File: rtl/wave_pkg.sv
// Shared FSM state encoding, default widths and UART frame constants for the readback path.
// The CHECK state exists only when READBACK_CHECKSUM_EN is defined.
package wave_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 16;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        SEND_LO,
        SEND_HI,
`ifdef READBACK_CHECKSUM_EN
        CHECK,
`endif
        FINISH
    } state_t;

endpackage

// File: rtl/wave_readback_if.sv
// Sample memory read port: the readback engine is master, the memory is slave.
// Read data is expected exactly one cycle after rd_enable.
interface wave_readback_if
    import wave_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  rd_enable;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output rd_enable,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_enable,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready is also high in the final stop-bit cycle, so a byte loaded
// then starts its start bit immediately after the previous stop bit with no idle gap.
module uart_tx_byte
    import wave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int          SHIFT_W   = UART_DATA_BITS + UART_STOP_BITS;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    // bit index 0 is the start bit, SHIFT_W is the (last) stop bit
    localparam logic [3:0]  LAST_BIT  = 4'(SHIFT_W);

    logic               active_reg;
    logic [15:0]        baud_cnt_reg;
    logic [3:0]         bit_cnt_reg;
    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] shift_next;
    logic               txd_reg;
    logic               bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign ready   = !active_reg || (bit_end && (bit_cnt_reg == LAST_BIT));
    assign txd     = txd_reg;

    for (genvar gi = 0; gi < SHIFT_W; gi++) begin : g_shift
        if (gi == SHIFT_W - 1) begin : g_fill
            assign shift_next[gi] = 1'b1;
        end else begin : g_move
            assign shift_next[gi] = shift_reg[gi+1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
        end else if (load && ready) begin
            active_reg   <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= {{UART_STOP_BITS{1'b1}}, data};
            txd_reg      <= 1'b0;
        end else if (active_reg) begin
            if (bit_end) begin
                baud_cnt_reg <= '0;
                if (bit_cnt_reg == LAST_BIT) begin
                    active_reg <= 1'b0;
                    txd_reg    <= 1'b1;
                end else begin
                    txd_reg     <= shift_reg[0];
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: rtl/wave_readback.sv
// Streams count samples from sample memory out of the UART, low byte first, addresses wrapping.
// Define READBACK_CHECKSUM_EN to append one XOR-of-all-bytes checksum byte after the last sample.
module wave_readback
    import wave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    wave_readback_if.master       mem,
    output logic                  txd,
    output logic                  busy,
    output logic                  done
);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] remain_reg, remain_next;
    logic [DATA_WIDTH-1:0] sample_reg, sample_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  rd_enable_reg, rd_enable_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                  tx_load;
    logic [7:0]            tx_byte;
    logic                  tx_ready;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]            csum_reg, csum_next;
`endif

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        sample_next = sample_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        tx_load     = 1'b0;
        tx_byte     = sample_reg[7:0];
`ifdef READBACK_CHECKSUM_EN
        csum_next   = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next   = start_addr;
                    remain_next = count;
                    busy_next   = 1'b1;
`ifdef READBACK_CHECKSUM_EN
                    csum_next   = '0;
`endif
                    state_next  = (count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: state_next = WAIT_DATA;
            WAIT_DATA: begin
                sample_next = mem.rd_data;
                state_next  = SEND_LO;
            end
            SEND_LO: begin
                if (tx_ready) begin
                    tx_load    = 1'b1;
`ifdef READBACK_CHECKSUM_EN
                    csum_next  = csum_reg ^ sample_reg[7:0];
`endif
                    state_next = SEND_HI;
                end
            end
            SEND_HI: begin
                tx_byte = sample_reg[15:8];
                if (tx_ready) begin
                    tx_load     = 1'b1;
                    remain_next = remain_reg - ADDR_WIDTH'(1);
`ifdef READBACK_CHECKSUM_EN
                    csum_next   = csum_reg ^ sample_reg[15:8];
`endif
                    if (remain_reg == ADDR_WIDTH'(1)) begin
`ifdef READBACK_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = FINISH;
`endif
                    end else begin
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        state_next = FETCH;
                    end
                end
            end
`ifdef READBACK_CHECKSUM_EN
            CHECK: begin
                tx_byte = csum_reg;
                if (tx_ready) begin
                    tx_load    = 1'b1;
                    state_next = FINISH;
                end
            end
`endif
            // hold off completion until the serializer has shifted out the last stop bit
            FINISH: begin
                if (tx_ready) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        rd_enable_next = (state_next == FETCH);
        rd_addr_next   = rd_enable_next ? addr_next : rd_addr_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remain_reg    <= '0;
            sample_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_enable_reg <= 1'b0;
            rd_addr_reg   <= '0;
`ifdef READBACK_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remain_reg    <= remain_next;
            sample_reg    <= sample_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            rd_enable_reg <= rd_enable_next;
            rd_addr_reg   <= rd_addr_next;
`ifdef READBACK_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (tx_load),
        .data  (tx_byte),
        .ready (tx_ready),
        .txd   (txd)
    );

    assign mem.rd_enable = rd_enable_reg;
    assign mem.rd_addr   = rd_addr_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: doc/wave_readback.md
WAVE_READBACK -- requirements
Module: wave_readback

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434; clk cycles per UART bit, legal range 4..65535.
REQ-002 Parameter ADDR_WIDTH, default 12; sample memory address width.
REQ-003 Parameter DATA_WIDTH, default 16; sample width, fixed at two bytes.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a readback.
REQ-007 start_addr  input  ADDR_WIDTH  first sample address, sampled with start.
REQ-008 count  input  ADDR_WIDTH  number of samples to send, sampled with start.
REQ-009 rd_enable  output  1  sample memory read strobe.
REQ-010 rd_addr  output  ADDR_WIDTH  sample memory read address.
REQ-011 rd_data  input  DATA_WIDTH  read data, valid exactly one cycle after rd_enable.
REQ-012 txd  output  1  UART 8N1 serial out, idle high.
REQ-013 busy  output  1  high from the cycle after an accepted start until done.
REQ-014 done  output  1  one-cycle pulse when the readback completes.

Function
REQ-015 FSM states: IDLE, FETCH, WAIT_DATA, SEND_LO, SEND_HI, (CHECK), FINISH.
REQ-016 IDLE: start=1 latches start_addr/count; count=0 -> FINISH; else -> FETCH.
REQ-017 FETCH: rd_enable=1 for one cycle, rd_addr=current address; -> WAIT_DATA.
REQ-018 WAIT_DATA: capture rd_data into sample register; -> SEND_LO.
REQ-019 SEND_LO transmits sample[7:0]; SEND_HI transmits sample[15:8] (little-endian).
REQ-020 After SEND_HI: remaining count decrements; nonzero -> FETCH with address+1; zero -> CHECK if enabled, else FINISH.
REQ-021 Address increment wraps modulo 2^ADDR_WIDTH (4095 -> 0).
REQ-022 FINISH: done=1 for one cycle, busy drops same cycle, -> IDLE.
REQ-023 start while busy is ignored; no latching, no effect on the transfer in progress.
REQ-024 Byte frame: start bit 0, eight data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles.
REQ-025 Start bit drives txd the cycle after the byte is loaded into the serializer.
REQ-026 Back-to-back bytes: next start bit follows the previous stop bit with at most 3 idle-high cycles inter-sample, 0 between LO and HI.
REQ-027 rd_enable is high only in FETCH; rd_addr holds its value outside FETCH.

Reset
REQ-028 Reset asserted: FSM -> IDLE, txd=1, busy=0, done=0, rd_enable=0, rd_addr=0, all counters 0.
REQ-029 Reset mid-frame aborts immediately; txd high on the reset assertion, no partial byte resumed after release.

Configuration
REQ-030 Macro READBACK_CHECKSUM_EN defined: after the last sample, CHECK sends one byte = XOR of all sample bytes sent, then FINISH.
REQ-031 Macro undefined: CHECK state, its byte, and the XOR accumulator are absent; SEND_HI of last sample goes straight to FINISH.
REQ-032 count=0 sends no bytes in either configuration, checksum included.

Structure
REQ-033 Shared package wave_pkg holds the FSM state enum, ADDR_WIDTH/DATA_WIDTH defaults, and the UART frame constants (data bits 8, stop bits 1).
REQ-034 Sub-module uart_tx_byte: load/byte in, ready out, txd out, CLKS_PER_BIT parameter; owns the baud and bit counters.

Verification (bench CLKS_PER_BIT=4)
REQ-035 start_addr=0x010, count=1, mem[0x010]=0xA55A -> bytes 0x5A,0xA5 on txd, each 40 cycles; one done pulse.
REQ-036 start_addr=0xFFF, count=2, mem[0xFFF]=0x1234, mem[0x000]=0xBEEF -> rd_addr 0xFFF then 0x000; bytes 34,12,EF,BE.
REQ-037 count=0 -> done pulse 2 cycles after start, txd constantly 1, rd_enable never asserted.
REQ-038 Second start with different addr issued mid-transfer -> ignored; output identical to single-start run.
REQ-039 reset deasserted-to-asserted during data bit 3 of byte 2 -> txd=1 same cycle; after release, IDLE, busy=0, no further bytes.
REQ-040 READBACK_CHECKSUM_EN, samples 0x0102,0x0304 -> bytes 02,01,04,03 then checksum 0x04; done after checksum stop bit.
